// File: rtl/musicbox_sdram_pkg.sv
// Shared constants and types for the musicbox SDRAM access path.
package musicbox_sdram_pkg;

  localparam int unsigned NUM_REQ         = 3;
  localparam int unsigned ADDR_W          = 24;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned MAX_OUTSTANDING = 4;

  localparam int unsigned REQ_RECORD  = 0;
  localparam int unsigned REQ_RECPLAY = 1;
  localparam int unsigned REQ_SONG    = 2;

  typedef logic [$clog2(NUM_REQ)-1:0] tag_t;

  typedef enum logic {
    StArb,
    StIssue
  } arbState_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester tags for reads in flight; push and pop may coincide even when full.
module sdram_arb_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clock_50Mhz,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushTag,
  input  logic             pop,
  output logic [WIDTH-1:0] popTag,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
  logic [PtrW:0]    countQ;
  logic             doPush, doPop;

  assign full   = (countQ == (PtrW + 1)'(DEPTH));
  assign empty  = (countQ == '0);
  assign doPop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign doPush = push & (~full | doPop);
  assign popTag = slots[rdPtrQ];

  always_ff @(posedge clock_50Mhz) begin
    if (doPush) begin
      slots[wrPtrQ] <= pushTag;
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) begin
        wrPtrQ <= wrPtrQ + 1'b1;
      end
      if (doPop) begin
        rdPtrQ <= rdPtrQ + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_access_arbiter.sv
// Shares one SDRAM controller port among the audio requesters, routing read data back by tag.
// Define SDRAM_ARB_RECORD_PRIORITY_EN to give the record-write requester fixed priority.
module sdram_access_arbiter #(
  parameter int unsigned NUM_REQ         = musicbox_sdram_pkg::NUM_REQ,
  parameter int unsigned ADDR_W          = musicbox_sdram_pkg::ADDR_W,
  parameter int unsigned DATA_W          = musicbox_sdram_pkg::DATA_W,
  parameter int unsigned MAX_OUTSTANDING = musicbox_sdram_pkg::MAX_OUTSTANDING
) (
  input  logic                      clock_50Mhz,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_req,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      protocol_error
);

  import musicbox_sdram_pkg::*;

  localparam int unsigned TagW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arbState_t         stateQ, stateD;
  logic [TagW-1:0]   selQ, selD;
  logic [TagW-1:0]   rrPtrQ, rrPtrD;
  logic [TagW-1:0]   winner;
  logic [TagW-1:0]   popTag;
  logic [NUM_REQ-1:0] eligible, rrEligible;
  logic              found;
  logic              advanceRr;
  logic              accept;
  logic              tagPush, tagPop;
  logic              fifoFull, fifoEmpty;
  logic              memReqD, memWriteD;
  logic [ADDR_W-1:0] memAddrD;
  logic [DATA_W-1:0] memWdataD;
  int unsigned       idx;

  // Reads need a free tag slot; writes never wait on the FIFO.
  assign eligible = req & (fifoFull ? req_write : {NUM_REQ{1'b1}});

`ifdef SDRAM_ARB_RECORD_PRIORITY_EN
  assign advanceRr = (selQ != TagW'(REQ_RECORD));
`else
  assign advanceRr = 1'b1;
`endif

  always_comb begin
    found      = 1'b0;
    winner     = '0;
    idx        = 0;
    rrEligible = eligible;
`ifdef SDRAM_ARB_RECORD_PRIORITY_EN
    if (eligible[REQ_RECORD]) begin
      found  = 1'b1;
      winner = TagW'(REQ_RECORD);
    end
    rrEligible[REQ_RECORD] = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rrPtrQ) + i) % NUM_REQ;
      if (!found && rrEligible[idx[TagW-1:0]]) begin
        found  = 1'b1;
        winner = idx[TagW-1:0];
      end
    end
  end

  assign accept  = (stateQ == StIssue) & mem_ready & ~reset;
  assign tagPush = accept & ~mem_write;
  assign tagPop  = mem_rvalid & ~fifoEmpty;

  always_comb begin
    gnt = '0;
    if (accept) begin
      gnt[selQ] = 1'b1;
    end
  end

  always_comb begin
    stateD    = stateQ;
    selD      = selQ;
    rrPtrD    = rrPtrQ;
    memReqD   = mem_req;
    memWriteD = mem_write;
    memAddrD  = mem_addr;
    memWdataD = mem_wdata;
    case (stateQ)
      StArb: begin
        memReqD = 1'b0;
        if (found) begin
          stateD    = StIssue;
          selD      = winner;
          memReqD   = 1'b1;
          memWriteD = req_write[winner];
          memAddrD  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          memWdataD = req_wdata[int'(winner)*DATA_W +: DATA_W];
        end
      end
      StIssue: begin
        // Request fields stay frozen until the controller takes them.
        if (mem_ready) begin
          stateD  = StArb;
          memReqD = 1'b0;
          if (advanceRr) begin
            rrPtrD = (selQ == TagW'(NUM_REQ - 1)) ? '0 : selQ + 1'b1;
          end
        end
      end
      default: stateD = StArb;
    endcase
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      stateQ    <= StArb;
      selQ      <= '0;
      rrPtrQ    <= '0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      stateQ    <= stateD;
      selQ      <= selD;
      rrPtrQ    <= rrPtrD;
      mem_req   <= memReqD;
      mem_write <= memWriteD;
      mem_addr  <= memAddrD;
      mem_wdata <= memWdataD;
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      rvalid         <= '0;
      rdata          <= '0;
      protocol_error <= 1'b0;
    end else begin
      rvalid <= '0;
      if (tagPop) begin
        rvalid[popTag] <= 1'b1;
        rdata          <= mem_rdata;
      end
      if (mem_rvalid && fifoEmpty) begin
        protocol_error <= 1'b1;
      end
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(TagW)
  ) u_tagFifo (
    .clock_50Mhz(clock_50Mhz),
    .reset      (reset),
    .push       (tagPush),
    .pushTag    (selQ),
    .pop        (mem_rvalid),
    .popTag     (popTag),
    .full       (fifoFull),
    .empty      (fifoEmpty)
  );

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed and randomized checks of sdram_access_arbiter against a transaction-level model.
module tb_sdram_access_arbiter;

  localparam int NR = 3;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int MO = 4;

  logic             clock_50Mhz = 1'b0;
  logic             reset       = 1'b1;
  logic [NR-1:0]    req         = '0;
  logic [NR-1:0]    req_write   = '0;
  logic [NR*AW-1:0] req_addr    = '0;
  logic [NR*DW-1:0] req_wdata   = '0;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata;
  logic             mem_req, mem_write;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ready   = 1'b0;
  logic             mem_rvalid  = 1'b0;
  logic [DW-1:0]    mem_rdata   = '0;
  logic             protocol_error;

  int checks = 0;
  int errors = 0;

  always #10 clock_50Mhz = ~clock_50Mhz;

  sdram_access_arbiter dut (
    .clock_50Mhz   (clock_50Mhz),
    .reset         (reset),
    .req           (req),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .protocol_error(protocol_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_50Mhz);
    #1;
  endtask

  task automatic setReq(input int i, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    req_write[i]           = wr;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req[i]                 = 1'b1;
  endtask

  task automatic awaitGnt(input int i, input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      #1;
      ok = gnt[i];
      tick();
    end
  endtask

  task automatic awaitAny(input int limit, output logic [NR-1:0] g);
    g = '0;
    for (int c = 0; c < limit && g == '0; c++) begin
      #1;
      g = gnt;
      tick();
    end
  endtask

  // Arbitration rule: optional fixed priority for requester 0, otherwise first eligible from ptr.
  function automatic int pick(input logic [NR-1:0] el, input int ptr);
`ifdef SDRAM_ARB_RECORD_PRIORITY_EN
    if (el[0]) return 0;
    el[0] = 1'b0;
`endif
    for (int i = 0; i < NR; i++) begin
      if (el[(ptr + i) % NR]) return (ptr + i) % NR;
    end
    return 0;
  endfunction

  bit              ok;
  logic [NR-1:0]   seen, g;
  logic [NR-1:0]   order [4];
  logic [NR-1:0]   expOrd;
  bit              pend [NR];
  bit              pWr [NR];
  logic [AW-1:0]   pAddr [NR];
  logic [DW-1:0]   pData [NR];
  int              retQ [$];
  int              ptr, win;
  bit              issuing;
  logic [NR-1:0]   el, expG, expRv;
  logic [DW-1:0]   expRd;
  logic [31:0]     r;

  initial begin
    // Reset values
    tick();
    tick();
    reset = 1'b0;
    check("reset.mem_req", mem_req, 0);
    check("reset.mem_write", mem_write, 0);
    check("reset.mem_addr", mem_addr, 0);
    check("reset.mem_wdata", mem_wdata, 0);
    check("reset.rvalid", rvalid, 0);
    check("reset.rdata", rdata, 0);
    check("reset.protocol_error", protocol_error, 0);
    check("reset.gnt", gnt, 0);

    // Single read with a 3-cycle controller latency
    setReq(1, 1'b0, 24'h000010, 16'h0);
    mem_ready = 1'b1;
    #1 check("single.gnt_in_arb", gnt, 0);
    tick();
    check("single.mem_req", mem_req, 1);
    check("single.mem_addr", mem_addr, 24'h000010);
    check("single.mem_write", mem_write, 0);
    #1 check("single.gnt", gnt, 3'b010);
    tick();
    req = '0;
    check("single.mem_req_drop", mem_req, 0);
    #1 check("single.gnt_once", gnt, 0);
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    tick();
    mem_rvalid = 1'b0;
    check("single.rvalid", rvalid, 3'b010);
    check("single.rdata", rdata, 16'hBEEF);
    tick();
    check("single.rvalid_once", rvalid, 0);

    // Controller stall: request fields frozen until mem_ready
    mem_ready = 1'b0;
    setReq(2, 1'b1, 24'h123456, 16'hA5A5);
    tick();
    for (int c = 0; c < 10; c++) begin
      check("stall.mem_req", mem_req, 1);
      check("stall.mem_addr", mem_addr, 24'h123456);
      check("stall.mem_wdata", mem_wdata, 16'hA5A5);
      #1 check("stall.gnt", gnt, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1 check("stall.gnt_release", gnt, 3'b100);
    tick();
    req = '0;
    check("stall.mem_req_drop", mem_req, 0);

    // Tag FIFO full: reads blocked, writes still pass
    for (int k = 0; k < MO; k++) begin
      setReq(1, 1'b0, 24'h000100 + AW'(k), 16'h0);
      awaitGnt(1, 10, ok);
      req[1] = 1'b0;
      check("full.fill_gnt", ok, 1);
    end
    setReq(1, 1'b0, 24'h000200, 16'h0);
    setReq(0, 1'b1, 24'h000300, 16'h1234);
    seen = '0;
    for (int c = 0; c < 8; c++) begin
      #1 seen = seen | gnt;
      tick();
      if (seen[0]) req[0] = 1'b0;
    end
    check("full.write_granted", seen[0], 1);
    check("full.read_blocked", seen[1], 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1111;
    tick();
    mem_rvalid = 1'b0;
    check("full.first_return", rvalid, 3'b010);
    awaitGnt(1, 10, ok);
    req[1] = 1'b0;
    check("full.fifth_read_gnt", ok, 1);
    for (int k = 0; k < MO; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h2000 + DW'(k);
      tick();
      check("full.drain_rvalid", rvalid, 3'b010);
      check("full.drain_rdata", rdata, 16'h2000 + DW'(k));
    end
    mem_rvalid = 1'b0;
    tick();

    // Spurious return with no tag outstanding
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    check("spurious.rvalid", rvalid, 0);
    check("spurious.protocol_error", protocol_error, 1);
    tick();
    tick();
    tick();
    check("spurious.sticky", protocol_error, 1);

    // Reset while in ISSUE with two reads outstanding
    for (int k = 0; k < 2; k++) begin
      setReq(1, 1'b0, 24'h000500 + AW'(k), 16'h0);
      awaitGnt(1, 10, ok);
      req[1] = 1'b0;
      check("rst.pre_gnt", ok, 1);
    end
    mem_ready = 1'b0;
    setReq(2, 1'b0, 24'h000600, 16'h0);
    tick();
    check("rst.in_issue", mem_req, 1);
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
    check("rst.mem_req", mem_req, 0);
    check("rst.protocol_error", protocol_error, 0);
    check("rst.rvalid", rvalid, 0);

    // Contention, all reads, requests held
    mem_ready = 1'b1;
    for (int i = 0; i < NR; i++) setReq(i, 1'b0, 24'h000700 + AW'(i), 16'h0);
    for (int k = 0; k < 4; k++) begin
      awaitAny(10, g);
      order[k] = g;
`ifdef SDRAM_ARB_RECORD_PRIORITY_EN
      expOrd = 3'b001;
`else
      expOrd = NR'(1 << (k % NR));
`endif
      check("contend.gnt_order", g, expOrd);
    end
    req = '0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h5000 + DW'(k);
      tick();
      check("contend.rvalid_order", rvalid, order[k]);
      check("contend.rdata", rdata, 16'h5000 + DW'(k));
    end
    tick();
    mem_rvalid = 1'b0;
    check("contend.fifo_empty_rvalid", rvalid, 0);
    check("contend.fifo_empty_perr", protocol_error, 1);

    // Randomized traffic against the transaction model
    reset     = 1'b1;
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    ptr     = 0;
    win     = 0;
    issuing = 1'b0;
    expRv   = '0;
    expRd   = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      check("rand.rvalid", rvalid, expRv);
      if (expRv != '0) check("rand.rdata", rdata, expRd);
      check("rand.mem_req", mem_req, issuing);
      if (issuing) begin
        check("rand.mem_write", mem_write, pWr[win]);
        check("rand.mem_addr", mem_addr, pAddr[win]);
        check("rand.mem_wdata", mem_wdata, pData[win]);
      end
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          pWr[i]   = 1'($urandom_range(0, 1));
          r        = $urandom;
          pAddr[i] = r[AW-1:0];
          r        = $urandom;
          pData[i] = r[DW-1:0];
        end
        req[i]                = pend[i];
        req_write[i]          = pWr[i];
        req_addr[i*AW +: AW]  = pAddr[i];
        req_wdata[i*DW +: DW] = pData[i];
        el[i] = pend[i] && (pWr[i] || retQ.size() < MO);
      end
      mem_ready  = ($urandom_range(0, 3) != 0);
      mem_rvalid = (retQ.size() > 0) && ($urandom_range(0, 2) != 0);
      r          = $urandom;
      mem_rdata  = r[DW-1:0];
      #1;
      expG = (issuing && mem_ready) ? NR'(1 << win) : '0;
      check("rand.gnt", gnt, expG);
      expRv = '0;
      if (mem_rvalid) begin
        expRv = NR'(1 << retQ.pop_front());
        expRd = mem_rdata;
      end
      if (issuing) begin
        if (mem_ready) begin
          issuing   = 1'b0;
          pend[win] = 1'b0;
          if (!pWr[win]) retQ.push_back(win);
`ifdef SDRAM_ARB_RECORD_PRIORITY_EN
          if (win != 0) ptr = (win + 1) % NR;
`else
          ptr = (win + 1) % NR;
`endif
        end
      end else if (el != '0) begin
        win     = pick(el, ptr);
        issuing = 1'b1;
      end
      tick();
    end
    check("rand.no_protocol_error", protocol_error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_access_arbiter.md
# sdram_access_arbiter

Shares the board's single SDRAM controller port between the audio requesters: recording capture (write), recording playback (read) and stored-song playback (read). It selects one single-word request at a time, holds it on the controller's request port until the controller accepts it, and routes returned read data back to the originating requester through an in-order tag FIFO. It sits between the recording/playback engines and the SDRAM controller, on the 50 MHz domain.

## Interface
- NUM_REQ, 3, number of requesters (index 0 = record write, 1 = recording playback, 2 = song playback)
- ADDR_W, 24, word address width
- DATA_W, 16, SDRAM data width (matches board bus)
- MAX_OUTSTANDING, 4, read tags in flight; power of two, ≥2
- clock_50Mhz  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request; held high with stable addr/write/wdata until gnt
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ×ADDR_W  word address per requester
- req_wdata  in  NUM_REQ×DATA_W  write data per requester
- gnt  out  NUM_REQ  one-cycle pulse: request accepted by controller
- rvalid  out  NUM_REQ  one-cycle pulse: rdata belongs to this requester
- rdata  out  DATA_W  read data, shared, qualified by rvalid
- mem_req  out  1  request to SDRAM controller
- mem_write  out  1  write/read select
- mem_addr  out  ADDR_W  address to controller
- mem_wdata  out  DATA_W  write data to controller
- mem_ready  in  1  controller accepts when mem_req & mem_ready
- mem_rvalid  in  1  controller read data valid, in issue order
- mem_rdata  in  DATA_W  controller read data
- protocol_error  out  1  sticky: mem_rvalid with no outstanding tag

## Operation
- FSM states: ARB, ISSUE.
- ARB: eligible = req bits, with reads masked when tag FIFO full (writes never masked). If any eligible, pick round-robin starting at rr_ptr; register mem_req=1, mem_write/addr/wdata from winner, sel=winner; go ISSUE. Else stay, mem_req=0.
- ISSUE: hold mem_* stable. On mem_ready: gnt[sel]=1 that cycle, push sel into tag FIFO if read, rr_ptr = sel+1 (mod NUM_REQ), mem_req=0 next cycle, return to ARB. Requester dropping req while in ISSUE is illegal; the arbiter ignores it and completes the access.
- Read return: on mem_rvalid pop tag t; next cycle rvalid[t]=1, rdata=registered mem_rdata. Push and pop in same cycle allowed, including at full.
- mem_rvalid with empty FIFO: no rvalid, protocol_error set until reset.
- Reset values: mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, gnt=0, rvalid=0, rdata=0, protocol_error=0, rr_ptr=0, FIFO empty, state ARB.
- Reset mid-transaction: request abandoned immediately, outstanding tags discarded; the SDRAM controller shares the reset, so no stale data returns.

## Timing
- req rising in cycle N (state ARB) → mem_req high in N+1; gnt earliest N+1 if mem_ready high in N+1.
- Back-to-back: one accepted access per 2 cycles minimum (ISSUE→ARB→ISSUE).
- Read latency through arbiter: rvalid exactly 1 cycle after mem_rvalid.
- Worst-case grant wait for an eligible requester: NUM_REQ-1 other accesses (round-robin), plus controller stall.

## Configuration
- SDRAM_ARB_RECORD_PRIORITY_EN: defined → requester 0 wins every ARB decision it participates in (fixed priority for record write, remaining requesters round-robin among themselves when req[0]=0); rr_ptr not advanced by requester 0 grants. Undefined → pure round-robin over all requesters.

## Structure
- Package musicbox_sdram_pkg: ADDR_W/DATA_W constants, requester index constants REQ_RECORD=0, REQ_RECPLAY=1, REQ_SONG=2, tag typedef (logic [$clog2(NUM_REQ)-1:0]), arbiter state enum.
- One sub-module: sdram_arb_tag_fifo (synchronous FIFO, depth MAX_OUTSTANDING, simultaneous push/pop, full/empty flags).

## Test plan
- Single read: req[1]=1 addr 0x000010, mem_ready=1, mem_rvalid 3 cycles after accept with 0xBEEF → gnt[1] one pulse, rvalid[1]=1 with rdata=0xBEEF one cycle later.
- Contention: req=3'b111 held, all reads → gnts in order 0,1,2,0,…; rvalid order matches grant order.
- Tag full: MAX_OUTSTANDING=4, 4 reads accepted, no returns → fifth read not issued, concurrent write on req[0] still granted; one mem_rvalid → fifth read issued.
- Controller stall: mem_ready=0 for 10 cycles → mem_req, mem_addr, mem_wdata stable for all 10; gnt only on cycle mem_ready rises.
- Spurious return: mem_rvalid with FIFO empty → protocol_error=1, no rvalid; stays set until reset.
- Reset in ISSUE with 2 reads outstanding → next cycle mem_req=0, FIFO empty, rr_ptr=0; with SDRAM_ARB_RECORD_PRIORITY_EN, req=3'b111 → req[0] granted on every ARB decision.
